// File: rtl/vtg_pkg.sv
// Shared timing/window types and standard video modes
// for the windowed video timing generator.
package vtg_pkg;

    localparam int VTG_XW = 12;
    localparam int VTG_YW = 12;

    typedef struct packed {
        logic [VTG_XW-1:0] h_total;
        logic [VTG_XW-1:0] h_sync;
        logic [VTG_XW-1:0] h_bp;
        logic [VTG_XW-1:0] h_act;
        logic [VTG_YW-1:0] v_total;
        logic [VTG_YW-1:0] v_sync;
        logic [VTG_YW-1:0] v_bp;
        logic [VTG_YW-1:0] v_act;
    } vtg_timing_t;

    typedef struct packed {
        logic [VTG_XW-1:0] x0;
        logic [VTG_YW-1:0] y0;
        logic [VTG_XW-1:0] w;
        logic [VTG_YW-1:0] h;
    } vtg_win_t;

    localparam vtg_timing_t VTG_1080P = '{
        h_total: 12'd2200, h_sync: 12'd44, h_bp: 12'd148, h_act: 12'd1920,
        v_total: 12'd1125, v_sync: 12'd5,  v_bp: 12'd36,  v_act: 12'd1080
    };

    localparam vtg_timing_t VTG_720P = '{
        h_total: 12'd1650, h_sync: 12'd40, h_bp: 12'd220, h_act: 12'd1280,
        v_total: 12'd750,  v_sync: 12'd5,  v_bp: 12'd20,  v_act: 12'd720
    };

    localparam vtg_win_t WIN_720_IN_1080 = '{
        x0: 12'd320, y0: 12'd180, w: 12'd1280, h: 12'd720
    };

endpackage

// File: rtl/vtg_window_counter.sv
// Raster h/v counters with staged timing set that is
// swapped into the live set only at the frame wrap.
module vtg_counter
    import vtg_pkg::*;
#(
    parameter int X_BITS = VTG_XW,
    parameter int Y_BITS = VTG_YW,
    parameter int W      = 6*VTG_XW + 6*VTG_YW + 2,
    parameter logic [W-1:0] RST_CFG = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_stb_i,
    input  logic [W-1:0]               cfg_i,
    output logic [X_BITS-1:0]          h_o,
    output logic [Y_BITS-1:0]          v_o,
    output logic [W-X_BITS-Y_BITS-1:0] live_o,
    output logic                       pending_o
);

    logic [X_BITS-1:0] h_q, h_d, h_tot;
    logic [Y_BITS-1:0] v_q, v_d, v_tot;
    logic [W-1:0]      live_q, stg_q;
    logic              pend_q;
    logic              h_end, v_end, wrap;

    assign h_tot = live_q[W-1 -: X_BITS];
    assign v_tot = live_q[W-X_BITS-1 -: Y_BITS];

    assign h_end = (h_q == h_tot - X_BITS'(1));
    assign v_end = (v_q == v_tot - Y_BITS'(1));
    assign wrap  = h_end && v_end;

    always_comb begin
        h_d = h_end ? '0 : h_q + X_BITS'(1);
        v_d = v_q;
        if (h_end)
            v_d = v_end ? '0 : v_q + Y_BITS'(1);
    end

    // A strobe landing on the wrap cycle only refills staging;
    // the set it carries waits for the following wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= '0;
            v_q    <= '0;
            live_q <= RST_CFG;
            stg_q  <= RST_CFG;
            pend_q <= 1'b0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            if (wrap && pend_q)
                live_q <= stg_q;
            if (cfg_stb_i) begin
                stg_q  <= cfg_i;
                pend_q <= 1'b1;
            end else if (wrap) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign h_o       = h_q;
    assign v_o       = v_q;
    assign live_o    = live_q[W-X_BITS-Y_BITS-1:0];
    assign pending_o = pend_q;

endmodule

// File: rtl/vtg_window.sv
// Video timing generator with windowed frame-buffer fetch;
// all outputs aligned to the source read latency.
module vtg_window
    import vtg_pkg::*;
#(
    parameter int X_BITS = 12,
    parameter int Y_BITS = 12,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2,
    parameter logic [DATA_W-1:0] FILL = 16'hFFFF,
    parameter int H_TOTAL = int'(VTG_1080P.h_total),
    parameter int H_SYNC  = int'(VTG_1080P.h_sync),
    parameter int H_BP    = int'(VTG_1080P.h_bp),
    parameter int H_ACT   = int'(VTG_1080P.h_act),
    parameter int V_TOTAL = int'(VTG_1080P.v_total),
    parameter int V_SYNC  = int'(VTG_1080P.v_sync),
    parameter int V_BP    = int'(VTG_1080P.v_bp),
    parameter int V_ACT   = int'(VTG_1080P.v_act),
    parameter int WIN_X0  = int'(WIN_720_IN_1080.x0),
    parameter int WIN_Y0  = int'(WIN_720_IN_1080.y0),
    parameter int WIN_W   = int'(WIN_720_IN_1080.w),
    parameter int WIN_H   = int'(WIN_720_IN_1080.h)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_stb,
    input  logic [X_BITS-1:0] cfg_h_total,
    input  logic [X_BITS-1:0] cfg_h_sync,
    input  logic [X_BITS-1:0] cfg_h_bp,
    input  logic [X_BITS-1:0] cfg_h_act,
    input  logic [Y_BITS-1:0] cfg_v_total,
    input  logic [Y_BITS-1:0] cfg_v_sync,
    input  logic [Y_BITS-1:0] cfg_v_bp,
    input  logic [Y_BITS-1:0] cfg_v_act,
    input  logic [X_BITS-1:0] cfg_win_x0,
    input  logic [X_BITS-1:0] cfg_win_w,
    input  logic [Y_BITS-1:0] cfg_win_y0,
    input  logic [Y_BITS-1:0] cfg_win_h,
    input  logic              cfg_hs_pol,
    input  logic              cfg_vs_pol,
    output logic              cfg_pending,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic [DATA_W-1:0] pix_out,
    output logic [X_BITS-1:0] pos_x,
    output logic [Y_BITS-1:0] pos_y,
    output logic              sof
);

    typedef struct packed {
        logic [X_BITS-1:0] h_sync;
        logic [X_BITS-1:0] h_bp;
        logic [X_BITS-1:0] h_act;
        logic [X_BITS-1:0] x0;
        logic [X_BITS-1:0] w;
        logic [Y_BITS-1:0] v_sync;
        logic [Y_BITS-1:0] v_bp;
        logic [Y_BITS-1:0] v_act;
        logic [Y_BITS-1:0] y0;
        logic [Y_BITS-1:0] wh;
        logic              hs_pol;
        logic              vs_pol;
    } rest_t;

    typedef struct packed {
        logic              hs;
        logic              vs;
        logic              de;
        logic              hit;
        logic              sof;
        logic [X_BITS-1:0] ax;
        logic [Y_BITS-1:0] ay;
    } pipe_t;

    localparam int CFG_W = X_BITS + Y_BITS + $bits(rest_t);

    localparam logic [CFG_W-1:0] RST_CFG = {
        X_BITS'(H_TOTAL), Y_BITS'(V_TOTAL),
        X_BITS'(H_SYNC), X_BITS'(H_BP), X_BITS'(H_ACT),
        X_BITS'(WIN_X0), X_BITS'(WIN_W),
        Y_BITS'(V_SYNC), Y_BITS'(V_BP), Y_BITS'(V_ACT),
        Y_BITS'(WIN_Y0), Y_BITS'(WIN_H),
        2'b11
    };

    logic [CFG_W-1:0]  cfg_in;
    rest_t             live;
    logic [X_BITS-1:0] h, ax;
    logic [Y_BITS-1:0] v, ay;
    logic [X_BITS:0]   h_beg, h_fin, x_lo, x_hi;
    logic [Y_BITS:0]   v_beg, v_fin, y_lo, y_hi;
    logic              de_h, de_v, hit_x, hit_y;
    pipe_t             cur, tail;
    pipe_t             dly_q [0:RD_LAT];

    assign cfg_in = {
        cfg_h_total, cfg_v_total,
        cfg_h_sync, cfg_h_bp, cfg_h_act, cfg_win_x0, cfg_win_w,
        cfg_v_sync, cfg_v_bp, cfg_v_act, cfg_win_y0, cfg_win_h,
        cfg_hs_pol, cfg_vs_pol
    };

    vtg_counter #(
        .X_BITS  (X_BITS),
        .Y_BITS  (Y_BITS),
        .W       (CFG_W),
        .RST_CFG (RST_CFG)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .cfg_stb_i (cfg_stb),
        .cfg_i     (cfg_in),
        .h_o       (h),
        .v_o       (v),
        .live_o    (live),
        .pending_o (cfg_pending)
    );

    // Bounds are one bit wider so origin+size cannot wrap.
    assign h_beg = {1'b0, live.h_sync} + {1'b0, live.h_bp};
    assign h_fin = h_beg + {1'b0, live.h_act};
    assign v_beg = {1'b0, live.v_sync} + {1'b0, live.v_bp};
    assign v_fin = v_beg + {1'b0, live.v_act};
    assign x_lo  = {1'b0, live.x0};
    assign x_hi  = x_lo + {1'b0, live.w};
    assign y_lo  = {1'b0, live.y0};
    assign y_hi  = y_lo + {1'b0, live.wh};

    assign ax    = h - live.h_sync - live.h_bp;
    assign ay    = v - live.v_sync - live.v_bp;
    assign de_h  = ({1'b0, h} >= h_beg) && ({1'b0, h} < h_fin);
    assign de_v  = ({1'b0, v} >= v_beg) && ({1'b0, v} < v_fin);
    assign hit_x = ({1'b0, ax} >= x_lo) && ({1'b0, ax} < x_hi);
    assign hit_y = ({1'b0, ay} >= y_lo) && ({1'b0, ay} < y_hi);

    always_comb begin
        cur     = '0;
        cur.hs  = (h < live.h_sync) ~^ live.hs_pol;
        cur.vs  = (v < live.v_sync) ~^ live.vs_pol;
        cur.de  = de_h && de_v;
        cur.hit = cur.de && hit_x && hit_y;
        cur.ax  = cur.de ? ax : '0;
        cur.ay  = cur.de ? ay : '0;
        cur.sof = cur.de && (ax == '0) && (ay == '0);
    end

    assign tail  = dly_q[RD_LAT];
    assign rd_en = dly_q[0].hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q   <= '{default: '0};
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
            de_out  <= 1'b0;
            sof     <= 1'b0;
            pix_out <= '0;
            pos_x   <= '0;
            pos_y   <= '0;
        end else begin
            dly_q[0] <= cur;
            for (int i = 1; i <= RD_LAT; i++)
                dly_q[i] <= dly_q[i-1];
            hs_out  <= tail.hs;
            vs_out  <= tail.vs;
            de_out  <= tail.de;
            sof     <= tail.sof;
            pos_x   <= tail.ax;
            pos_y   <= tail.ay;
            pix_out <= !tail.de ? '0 : (tail.hit ? rd_data : FILL);
        end
    end

endmodule

// File: tb/tb_vtg_window.sv
// Bench for vtg_window: raster reference model, read-latency
// reader model, two latencies, directed and random configs.
module tb_vtg_window;

    typedef struct {
        int ht, hs, hb, ha, vt, vs, vb, va;
        int x0, w, y0, wh;
        bit hp, vp;
    } mcfg_t;

    typedef struct {
        bit          rd, hs, vs, de, sof;
        logic [15:0] pix, tag;
        logic [11:0] px, py;
    } rec_t;

    localparam mcfg_t DEF = '{16, 1, 2, 12, 8, 1, 1, 5, 3, 20, 1, 10, 1'b1, 1'b1};
    localparam mcfg_t SMALL = '{20, 2, 3, 10, 10, 1, 2, 5, 2, 4, 1, 2, 1'b1, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_stb = 1'b0;
    mcfg_t       pc = DEF;
    logic [11:0] cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act;
    logic [11:0] cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act;
    logic [11:0] cfg_win_x0, cfg_win_w, cfg_win_y0, cfg_win_h;
    logic        cfg_hs_pol, cfg_vs_pol;

    logic        pend0, rd0, hs0, vs0, de0, sof0;
    logic [15:0] rdd0 = '0, pix0;
    logic [11:0] px0, py0;
    logic        pend1, rd1, hs1, vs1, de1, sof1;
    logic [15:0] rdd1 = '0, pix1;
    logic [11:0] px1, py1;

    int    n = 0, tests = 0, fails = 0, vfrom = 0;
    bit    armed = 0;
    int    m_idx = 0;
    mcfg_t m_live = DEF, m_stg = DEF;
    bit    m_pend = 0;
    rec_t  hist [256];
    bit    rs0 [256];
    bit    rs1 [256];
    int    c_hs, c_vs, c_de, c_rd, c_sof, c_de1, c_rd1;

    assign cfg_h_total = 12'(pc.ht);
    assign cfg_h_sync  = 12'(pc.hs);
    assign cfg_h_bp    = 12'(pc.hb);
    assign cfg_h_act   = 12'(pc.ha);
    assign cfg_v_total = 12'(pc.vt);
    assign cfg_v_sync  = 12'(pc.vs);
    assign cfg_v_bp    = 12'(pc.vb);
    assign cfg_v_act   = 12'(pc.va);
    assign cfg_win_x0  = 12'(pc.x0);
    assign cfg_win_w   = 12'(pc.w);
    assign cfg_win_y0  = 12'(pc.y0);
    assign cfg_win_h   = 12'(pc.wh);
    assign cfg_hs_pol  = pc.hp;
    assign cfg_vs_pol  = pc.vp;

    always #5 clk = ~clk;

    vtg_window #(
        .RD_LAT(2),
        .H_TOTAL(DEF.ht), .H_SYNC(DEF.hs), .H_BP(DEF.hb), .H_ACT(DEF.ha),
        .V_TOTAL(DEF.vt), .V_SYNC(DEF.vs), .V_BP(DEF.vb), .V_ACT(DEF.va),
        .WIN_X0(DEF.x0), .WIN_Y0(DEF.y0), .WIN_W(DEF.w), .WIN_H(DEF.wh)
    ) dut0 (
        .clk(clk), .rst(rst), .cfg_stb(cfg_stb),
        .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync),
        .cfg_h_bp(cfg_h_bp), .cfg_h_act(cfg_h_act),
        .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync),
        .cfg_v_bp(cfg_v_bp), .cfg_v_act(cfg_v_act),
        .cfg_win_x0(cfg_win_x0), .cfg_win_w(cfg_win_w),
        .cfg_win_y0(cfg_win_y0), .cfg_win_h(cfg_win_h),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .cfg_pending(pend0), .rd_en(rd0), .rd_data(rdd0),
        .hs_out(hs0), .vs_out(vs0), .de_out(de0), .pix_out(pix0),
        .pos_x(px0), .pos_y(py0), .sof(sof0)
    );

    vtg_window #(
        .RD_LAT(4),
        .H_TOTAL(DEF.ht), .H_SYNC(DEF.hs), .H_BP(DEF.hb), .H_ACT(DEF.ha),
        .V_TOTAL(DEF.vt), .V_SYNC(DEF.vs), .V_BP(DEF.vb), .V_ACT(DEF.va),
        .WIN_X0(DEF.x0), .WIN_Y0(DEF.y0), .WIN_W(DEF.w), .WIN_H(DEF.wh)
    ) dut1 (
        .clk(clk), .rst(rst), .cfg_stb(cfg_stb),
        .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync),
        .cfg_h_bp(cfg_h_bp), .cfg_h_act(cfg_h_act),
        .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync),
        .cfg_v_bp(cfg_v_bp), .cfg_v_act(cfg_v_act),
        .cfg_win_x0(cfg_win_x0), .cfg_win_w(cfg_win_w),
        .cfg_win_y0(cfg_win_y0), .cfg_win_h(cfg_win_h),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .cfg_pending(pend1), .rd_en(rd1), .rd_data(rdd1),
        .hs_out(hs1), .vs_out(vs1), .de_out(de1), .pix_out(pix1),
        .pos_x(px1), .pos_y(py1), .sof(sof1)
    );

    function automatic rec_t zero_rec();
        rec_t r;
        r.rd = 0; r.hs = 0; r.vs = 0; r.de = 0; r.sof = 0;
        r.pix = '0; r.tag = '0; r.px = '0; r.py = '0;
        return r;
    endfunction

    // Expected outputs for raster index idx of a frame under config c.
    function automatic rec_t exp_rec(int idx, mcfg_t c);
        rec_t r;
        int h, v, hb0, vb0, ax, ay;
        bit de, hit;
        logic [7:0] ax8, ay8;
        h   = idx % c.ht;
        v   = idx / c.ht;
        hb0 = c.hs + c.hb;
        vb0 = c.vs + c.vb;
        de  = (h >= hb0) && (h < hb0 + c.ha) && (v >= vb0) && (v < vb0 + c.va);
        ax  = h - hb0;
        ay  = v - vb0;
        hit = de && (ax >= c.x0) && (ax < c.x0 + c.w)
                 && (ay >= c.y0) && (ay < c.y0 + c.wh);
        ax8 = 8'(ax);
        ay8 = 8'(ay);
        r = zero_rec();
        r.hs  = ((h < c.hs) == c.hp);
        r.vs  = ((v < c.vs) == c.vp);
        r.de  = de;
        r.rd  = hit;
        r.tag = {ay8, ax8};
        r.px  = de ? 12'(ax) : 12'd0;
        r.py  = de ? 12'(ay) : 12'd0;
        r.pix = !de ? 16'h0000 : (hit ? {ay8, ax8} : 16'hFFFF);
        r.sof = de && (ax == 0) && (ay == 0);
        return r;
    endfunction

    function automatic rec_t past(int k);
        if (k < vfrom) return zero_rec();
        return hist[k & 255];
    endfunction

    task automatic chk(input string tg, input logic [63:0] o, input logic [63:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tg, n, o, e);
        end
    endtask

    task automatic chk_dut(input string nm, input int lat, input logic rd,
                           input logic hs, input logic vs, input logic de,
                           input logic sf, input logic [15:0] pix,
                           input logic [11:0] px, input logic [11:0] py);
        rec_t e1, e;
        e1 = past(n - 1);
        e  = past(n - lat - 2);
        chk({nm, "_rd_en"}, 64'(rd), 64'(e1.rd));
        chk({nm, "_hs_vs_de_sof"}, {hs, vs, de, sf}, {e.hs, e.vs, e.de, e.sof});
        chk({nm, "_pix"}, pix, e.pix);
        chk({nm, "_pos"}, {px, py}, {e.px, e.py});
    endtask

    task automatic step();
        bit wrap;
        @(posedge clk);
        #1;
        n++;
        if (rst) begin
            m_idx = 0; m_live = DEF; m_stg = DEF; m_pend = 0;
            vfrom = n; armed = 1;
        end else begin
            wrap = (m_idx == m_live.ht * m_live.vt - 1);
            if (wrap && m_pend) begin
                m_live = m_stg;
                m_pend = 0;
            end
            if (cfg_stb) begin
                m_stg  = pc;
                m_pend = 1;
            end
            m_idx = wrap ? 0 : m_idx + 1;
        end
        hist[n & 255] = exp_rec(m_idx, m_live);
        if (armed) begin
            chk("pending0", 64'(pend0), 64'(m_pend));
            chk("pending1", 64'(pend1), 64'(m_pend));
            chk_dut("d0", 2, rd0, hs0, vs0, de0, sof0, pix0, px0, py0);
            chk_dut("d1", 4, rd1, hs1, vs1, de1, sof1, pix1, px1, py1);
        end
        rs0[n & 255] = (rd0 === 1'b1);
        rs1[n & 255] = (rd1 === 1'b1);
        rdd0 = rs0[(n - 2) & 255] ? past(n - 3).tag : 16'($urandom);
        rdd1 = rs1[(n - 4) & 255] ? past(n - 5).tag : 16'($urandom);
    endtask

    task automatic strobe();
        cfg_stb = 1'b1;
        step();
        cfg_stb = 1'b0;
    endtask

    task automatic wait_apply();
        for (int i = 0; i < 3000 && m_pend; i++) step();
        chk("applied", 64'(pend0), 64'd0);
    endtask

    task automatic count(input int cyc);
        c_hs = 0; c_vs = 0; c_de = 0; c_rd = 0; c_sof = 0; c_de1 = 0; c_rd1 = 0;
        repeat (cyc) begin
            step();
            c_hs  += int'(hs0);
            c_vs  += int'(vs0);
            c_de  += int'(de0);
            c_rd  += int'(rd0);
            c_sof += int'(sof0);
            c_de1 += int'(de1);
            c_rd1 += int'(rd1);
        end
    endtask

    function automatic mcfg_t rand_cfg();
        mcfg_t c;
        c.hs = $urandom_range(3, 1);
        c.hb = $urandom_range(3, 0);
        c.ha = $urandom_range(12, 1);
        c.ht = c.hs + c.hb + c.ha + $urandom_range(4, 1);
        c.vs = $urandom_range(2, 1);
        c.vb = $urandom_range(2, 0);
        c.va = $urandom_range(6, 1);
        c.vt = c.vs + c.vb + c.va + $urandom_range(3, 1);
        c.x0 = $urandom_range(14, 0);
        c.w  = $urandom_range(16, 0);
        c.y0 = $urandom_range(7, 0);
        c.wh = $urandom_range(8, 0);
        c.hp = 1'($urandom_range(1, 0));
        c.vp = 1'($urandom_range(1, 0));
        return c;
    endfunction

    initial begin
        rst = 1'b1;
        repeat (3) step();
        chk("rst_state0", {hs0, vs0, de0, sof0, rd0, pend0, pix0, px0, py0}, 64'd0);
        chk("rst_state1", {hs1, vs1, de1, sof1, rd1, pend1, pix1, px1, py1}, 64'd0);
        rst = 1'b0;
        repeat (140) step();

        pc = SMALL;
        strobe();
        chk("pend_set", 64'(pend0), 64'd1);
        wait_apply();
        repeat (10) step();
        count(200);
        chk("small_hs", c_hs, 20);
        chk("small_vs", c_vs, 20);
        chk("small_de", c_de, 50);
        chk("small_rd", c_rd, 8);
        chk("small_sof", c_sof, 1);
        chk("small_de_l4", c_de1, 50);
        chk("small_rd_l4", c_rd1, 8);

        repeat (47) step();
        pc.ha = 8;
        strobe();
        wait_apply();
        repeat (10) step();
        count(200);
        chk("mid_de", c_de, 40);
        chk("mid_rd", c_rd, 8);

        for (int i = 0; i < 3000 && m_idx != m_live.ht * m_live.vt - 1; i++) step();
        pc.ha = 6;
        strobe();
        chk("wrap_pend", 64'(pend0), 64'd1);
        repeat (5) step();
        chk("wrap_not_yet", 64'(pend0), 64'd1);
        wait_apply();
        repeat (10) step();
        count(200);
        chk("wrap_de", c_de, 30);

        repeat (20) step();
        pc.ha = 7;
        strobe();
        repeat (30) step();
        pc.ha = 9;
        strobe();
        wait_apply();
        repeat (10) step();
        count(200);
        chk("two_stb_de", c_de, 45);

        pc.x0 = 1; pc.w = 4095; pc.y0 = 0; pc.wh = 4095;
        strobe();
        wait_apply();
        repeat (10) step();
        count(200);
        chk("wide_win_rd", c_rd, 40);
        chk("wide_win_rd_l4", c_rd1, 40);

        pc.hp = 1'b0;
        strobe();
        wait_apply();
        repeat (10) step();
        count(200);
        chk("hs_pol_low", c_hs, 180);

        for (int i = 0; i < 300 && !de0; i++) step();
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("mid_rst0", {hs0, vs0, de0, sof0, rd0, pend0, pix0, px0, py0}, 64'd0);
        chk("mid_rst1", {hs1, vs1, de1, sof1, rd1, pend1, pix1, px1, py1}, 64'd0);
        rst = 1'b0;
        pc = DEF;
        repeat (10) step();
        count(128);
        chk("dflt_de", c_de, 60);
        chk("dflt_hs", c_hs, 8);
        chk("dflt_rd", c_rd, 36);
        chk("dflt_rd_l4", c_rd1, 36);

        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(120, 1)) step();
            pc = rand_cfg();
            strobe();
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(40, 1)) step();
                pc = rand_cfg();
                strobe();
            end
            wait_apply();
            repeat ($urandom_range(300, 100)) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vtg_window.md
# vtg_window

Runtime-programmable video timing generator with a windowed pixel-fetch path, for the HDMI output chain. It generates HS/VS/DE from a timing set that can be reloaded at frame boundaries, and issues read requests to the frame-buffer reader only inside a programmable window. Everywhere else in the active area it outputs a fill colour. All outputs, including pixel coordinates, are aligned to a parametrised source read latency.

## Interface
- X_BITS, 12, horizontal counter/coordinate width
- Y_BITS, 12, vertical counter/coordinate width
- DATA_W, 16, pixel width (RGB565)
- RD_LAT, 2, cycles from `rd_en` to valid `rd_data` (≥1)
- FILL, 16'hFFFF, pixel value outside the window
- H_TOTAL/H_SYNC/H_BP/H_ACT, 2200/44/148/1920, reset-time horizontal timing
- V_TOTAL/V_SYNC/V_BP/V_ACT, 1125/5/36/1080, reset-time vertical timing
- WIN_X0/WIN_Y0/WIN_W/WIN_H, 320/180/1280/720, reset-time window (active-area coordinates)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- cfg_stb  in  1  one-cycle strobe; captures all cfg_* inputs into staging
- cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act  in  X_BITS each  horizontal timing
- cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act  in  Y_BITS each  vertical timing
- cfg_win_x0, cfg_win_w  in  X_BITS  window origin and width
- cfg_win_y0, cfg_win_h  in  Y_BITS  window origin and height
- cfg_hs_pol, cfg_vs_pol  in  1  sync polarity, 1 = active-high
- cfg_pending  out  1  staging is loaded but not yet applied
- rd_en  out  1  pixel read request to frame-buffer reader
- rd_data  in  DATA_W  pixel, valid RD_LAT cycles after rd_en
- hs_out, vs_out, de_out  out  1  syncs (polarity applied) and data enable
- pix_out  out  DATA_W  output pixel
- pos_x  out  X_BITS  active-area x of pix_out; 0 when de_out=0
- pos_y  out  Y_BITS  active-area y of pix_out; 0 when de_out=0
- sof  out  1  one-cycle pulse with the first de_out of each frame

## Operation
- The h counter runs 0..h_total-1. The v counter increments when h wraps and runs 0..v_total-1.
- Sync and active regions:
  - hs is active for h < h_sync.
  - vs is active for v < v_sync, changing at h=0.
  - de is active for h_sync+h_bp ≤ h < h_sync+h_bp+h_act, and likewise in v.
- Active coordinates: ax = h-h_sync-h_bp, ay = v-v_sync-v_bp.
- Window hit: win_x0 ≤ ax < win_x0+win_w and win_y0 ≤ ay < win_y0+win_h. Compare at X_BITS+1 / Y_BITS+1 width so that x0+w cannot wrap.
- rd_en = de & hit. It is never asserted outside de, so window parts beyond the active area are clipped.
- pix_out = rd_data when the delayed hit is set, otherwise FILL. pix_out is 0 when de_out=0.
- Config loading:
  - cfg_stb writes staging and sets cfg_pending. A second strobe before apply overwrites staging.
  - Staging is applied to the live set at frame wrap (h=h_total-1 and v=v_total-1), then cfg_pending clears.
  - A strobe in that same cycle is applied at the next wrap, not this one.
- Reset: the live set and staging take the parameter values, polarity = active-high, counters = 0, cfg_pending = 0.
- Config consistency (sums < totals, h_act ≥ 1) is the caller's responsibility and is not checked.

## Timing
- rd_en is registered: it asserts 1 cycle after the counter position it describes.
- hs_out/vs_out/de_out/pix_out/pos_x/pos_y/sof are registered and appear RD_LAT+1 cycles after the corresponding rd_en, which is RD_LAT+2 cycles after the counter position.
- All control goes through a single delay line of depth RD_LAT+1. Syncs keep their relative alignment with de.
- Reset values:
  - hs_out = vs_out = 0 (inactive, active-high default).
  - de_out = sof = rd_en = cfg_pending = 0.
  - pix_out = pos_x = pos_y = 0.
- Reset mid-frame: the pipeline is flushed to the reset values on the next clock. The first frame starts at h=v=0.
- Polarity change takes effect with the new frame's first output cycle; there is no glitch mid-frame.

## Structure
- Package `vtg_pkg`:
  - typedef `vtg_timing_t` (h/v total, sync, bp, act)
  - typedef `vtg_win_t` (x0, y0, w, h)
  - constants `VTG_1080P`, `VTG_720P`, `WIN_720_IN_1080`
- Sub-module `vtg_counter`: h/v counters, staging/live registers, frame-wrap apply, cfg_pending.
- The top level holds window compare, the delay line and output muxing.

## Test plan
- Small timing via cfg_stb after reset (h 20/2/3/10, v 10/1/2/5, window 2/1/4/2), wait one frame:
  - hs_out high 2 cycles per 20; vs_out high 20 cycles per 200.
  - de_out 10 cycles × 5 lines.
  - rd_en 4 cycles × 2 lines.
- Same timing, with rd_data driven by an ideal RD_LAT=2 model returning {ay, ax}:
  - pix_out equals {pos_y, pos_x} inside the window and FILL outside.
  - sof coincides with pos=(0,0).
- cfg_stb mid-frame with h_act=8:
  - Current frame keeps 10-pixel lines; cfg_pending stays high until wrap.
  - Next frame has 8-pixel lines.
- cfg_stb exactly at the wrap cycle → applied one frame later; two strobes in one frame → only the second set is used.
- cfg_hs_pol=0 → hs_out idles high and goes low for 2 cycles; reset mid-line → all outputs 0 next cycle; timing restarts with the parameter defaults.
- Default 1080p run with RD_LAT=1 and RD_LAT=4: de_out is 1920×1080 per 2200×1125; rd_en is 1280×720 starting at ax=320, ay=180.
